// File: rtl/riscv_div_seq.sv
// -----------------------------------------------------------------------------
// riscv_div_seq
//
// Multi-cycle integer divide / remainder unit for the EX stage (RISC-V M
// DIV, DIVU, REM and REMU). Radix-2 restoring divider that produces one
// quotient bit per clock, sequenced by a three-state FSM
// (IDLE -> CALC -> FINISH).
//
// Operands are captured from the inputs only in IDLE, so the ID stage may
// change op_a_i, op_b_i or operator_i while a divide is running.
//
// Two cases finish after one cycle without iterating:
//   - division by zero
//   - signed overflow (most negative value divided by -1)
//
// Ports
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   enable_i     divide instruction present in EX (a level, held until EX
//                advances)
//   operator_i   00 DIVU, 01 DIV, 10 REMU, 11 REM
//   op_a_i       dividend
//   op_b_i       divisor
//   result_o     quotient or remainder; non-zero only in FINISH
//   ready_o      unit done / not blocking EX
//   multicycle_o high while in CALC or FINISH
//   ex_ready_i   EX stage advancing this cycle
// -----------------------------------------------------------------------------
module riscv_div_seq #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [1:0]       operator_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             multicycle_o,
    input  logic             ex_ready_i
);

    localparam logic [WIDTH-1:0]     ZERO_VAL = '0;
    localparam logic [WIDTH-1:0]     ONES_VAL = '1;
    localparam logic [WIDTH-1:0]     MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t               state_reg,   state_next;
    logic [CNT_WIDTH-1:0] cnt_reg,     cnt_next;
    logic                 rem_sel_reg, rem_sel_next;   // 1: return remainder
    logic                 neg_q_reg,   neg_q_next;
    logic                 neg_r_reg,   neg_r_next;
    logic [WIDTH-1:0]     divisor_reg, divisor_next;   // |op_b|

    // quot_reg starts holding |op_a|. Each iteration shifts one dividend
    // bit out of the top and one quotient bit in at the bottom, so after
    // WIDTH iterations it holds the unsigned quotient.
    logic [WIDTH-1:0]     quot_reg,    quot_next;
    logic [WIDTH-1:0]     rem_reg,     rem_next;
    logic [WIDTH-1:0]     result_reg,  result_next;

    // ------------------------------------------------------------------
    // Operand conditioning (used only in IDLE)
    // ------------------------------------------------------------------
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             sgn_ovf;

    assign signed_op = operator_i[0];
    assign a_neg     = signed_op & op_a_i[WIDTH-1];
    assign b_neg     = signed_op & op_b_i[WIDTH-1];

    // Negating MIN_VAL yields MIN_VAL again. Read as an unsigned
    // magnitude, that is the correct absolute value.
    assign a_abs     = a_neg ? (ZERO_VAL - op_a_i) : op_a_i;
    assign b_abs     = b_neg ? (ZERO_VAL - op_b_i) : op_b_i;

    assign div_zero  = (op_b_i == ZERO_VAL);
    assign sgn_ovf   = signed_op & (op_a_i == MIN_VAL) & (op_b_i == ONES_VAL);

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    // The shifted partial remainder can reach 2*divisor-1, which needs
    // WIDTH+1 bits. The trial subtract therefore carries one extra bit,
    // so its top bit is a clean borrow (i.e. the sign of the difference).
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_iter;
    logic [WIDTH-1:0] quot_iter;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign rem_shift = {rem_reg, quot_reg[WIDTH-1]};
    assign trial     = {1'b0, rem_shift} - {2'b00, divisor_reg};
    assign q_bit     = ~trial[WIDTH+1];

    // When the subtract fails, rem_shift < divisor, so its top bit is 0
    // and truncating it to WIDTH bits is lossless.
    assign rem_iter  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quot_iter = {quot_reg[WIDTH-2:0], q_bit};

    // Sign correction: the quotient truncates toward zero, and the
    // remainder takes the sign of the dividend.
    assign quot_fix  = neg_q_reg ? (ZERO_VAL - quot_iter) : quot_iter;
    assign rem_fix   = neg_r_reg ? (ZERO_VAL - rem_iter)  : rem_iter;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rem_sel_reg <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            divisor_reg <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rem_sel_reg <= rem_sel_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            divisor_reg <= divisor_next;
            quot_reg    <= quot_next;
            rem_reg     <= rem_next;
            result_reg  <= result_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rem_sel_next = rem_sel_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        divisor_next = divisor_reg;
        quot_next    = quot_reg;
        rem_next     = rem_reg;
        result_next  = result_reg;
        ready_o      = 1'b0;

        case (state_reg)
            IDLE: begin
                // ready_o drops as soon as a divide shows up in EX, so it
                // can start in the same cycle as a previous FINISH->IDLE.
                ready_o = ~enable_i;
                if (enable_i) begin
                    rem_sel_next = operator_i[1];
                    neg_q_next   = signed_op & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
                    neg_r_next   = a_neg;
                    divisor_next = b_abs;
                    quot_next    = a_abs;
                    rem_next     = '0;
                    if (div_zero) begin
                        // Quotient is all ones; remainder is the raw dividend.
                        result_next = operator_i[1] ? op_a_i : ONES_VAL;
                        state_next  = FINISH;
                    end else if (sgn_ovf) begin
                        // Quotient is the dividend; remainder is zero.
                        result_next = operator_i[1] ? ZERO_VAL : MIN_VAL;
                        state_next  = FINISH;
                    end else begin
                        cnt_next    = CNT_LAST;
                        state_next  = CALC;
                    end
                end
            end

            CALC: begin
                if (!enable_i) begin
                    // Instruction flushed: drop the work and produce no result.
                    state_next = IDLE;
                end else begin
                    rem_next  = rem_iter;
                    quot_next = quot_iter;
                    if (cnt_reg == '0) begin
                        result_next = rem_sel_reg ? rem_fix : quot_fix;
                        state_next  = FINISH;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end

            FINISH: begin
                ready_o = 1'b1;
                if (!enable_i || ex_ready_i) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign multicycle_o = (state_reg != IDLE);

    // Gate the result so that no stale value leaks out after an abort or
    // outside FINISH.
    assign result_o = (state_reg == FINISH) ? result_reg : ZERO_VAL;

endmodule

// File: tb/tb_riscv_div_seq.sv
// -----------------------------------------------------------------------------
// tb_riscv_div_seq
//
// Directed testbench for riscv_div_seq.
//
// Inputs are driven 1 time unit after the rising clock edge. Outputs are
// sampled on the falling edge.
//
// "Cycle 0" is the cycle in which enable_i first rises for an operation.
// -----------------------------------------------------------------------------
module tb_riscv_div_seq;

    logic        clk;
    logic        rst_n;
    logic        enable_i;
    logic [1:0]  operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        multicycle_o;
    logic        ex_ready_i;

    int checks   = 0;
    int failures = 0;

    riscv_div_seq #(
        .WIDTH     (32),
        .CNT_WIDTH (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .operator_i   (operator_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .multicycle_o (multicycle_o),
        .ex_ready_i   (ex_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        enable_i   = 1'b1;
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
    endtask

    // EX advances out of FINISH, then ID withdraws the instruction.
    task automatic end_op;
        next_cyc();
        enable_i = 1'b0;
        next_cyc();
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", ready_o);
        end
        checks++;
        if (result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_result: got %h expected 00000000", result_o);
        end
        checks++;
        if (multicycle_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_multicycle: got %b expected 0", multicycle_o);
        end
        rst_n = 1'b1;
        next_cyc();
    endtask

    task automatic test_divu_basic;
        ex_ready_i = 1'b1;
        start_op(2'b00, 32'd100, 32'd7);
        for (int c = 0; c <= 32; c++) begin
            @(negedge clk);
            checks++;
            if (ready_o !== 1'b0) begin
                failures++;
                $display("FAIL divu_busy cycle %0d: ready_o got %b expected 0", c, ready_o);
            end
            next_cyc();
        end
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== 32'h0000000E) begin
            failures++;
            $display("FAIL divu_100_7: got ready=%b result=%h expected ready=1 result=0000000e", ready_o, result_o);
        end
        next_cyc();
        enable_i = 1'b0;
        @(negedge clk);
        checks++;
        if (multicycle_o !== 1'b0 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL divu_idle_after: got multicycle=%b ready=%b expected 0/1", multicycle_o, ready_o);
        end
        next_cyc();
    endtask

    task automatic test_signed;
        start_op(2'b11, 32'hFFFFFF9C, 32'd7);
        repeat (33) next_cyc();
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL rem_m100_7: got ready=%b result=%h expected ready=1 result=fffffffe", ready_o, result_o);
        end
        end_op();
    endtask

    task automatic test_special;
        start_op(2'b01, 32'd5, 32'd0);
        next_cyc();
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL div_by_zero: got ready=%b result=%h expected ready=1 result=ffffffff", ready_o, result_o);
        end
        end_op();

        start_op(2'b10, 32'd5, 32'd0);
        next_cyc();
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== 32'h00000005) begin
            failures++;
            $display("FAIL remu_by_zero: got ready=%b result=%h expected ready=1 result=00000005", ready_o, result_o);
        end
        end_op();

        start_op(2'b01, 32'h80000000, 32'hFFFFFFFF);
        next_cyc();
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== 32'h80000000) begin
            failures++;
            $display("FAIL div_overflow: got ready=%b result=%h expected ready=1 result=80000000", ready_o, result_o);
        end
        end_op();

        start_op(2'b11, 32'h80000000, 32'hFFFFFFFF);
        next_cyc();
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || multicycle_o !== 1'b1 || result_o !== 32'h0) begin
            failures++;
            $display("FAIL rem_overflow: got ready=%b multicycle=%b result=%h expected 1/1/00000000", ready_o, multicycle_o, result_o);
        end
        end_op();
    endtask

    task automatic test_hold;
        ex_ready_i = 1'b0;
        start_op(2'b00, 32'hFFFFFFFF, 32'd1);
        repeat (33) next_cyc();
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (ready_o !== 1'b1 || result_o !== 32'hFFFFFFFF) begin
                failures++;
                $display("FAIL hold cycle +%0d: got ready=%b result=%h expected ready=1 result=ffffffff", k, ready_o, result_o);
            end
            if (k < 10) next_cyc();
        end
        ex_ready_i = 1'b1;
        next_cyc();
        enable_i = 1'b0;
        @(negedge clk);
        checks++;
        if (multicycle_o !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: multicycle got %b expected 0", multicycle_o);
        end
        next_cyc();
    endtask

    task automatic test_abort;
        start_op(2'b00, 32'd1000, 32'd3);
        repeat (10) next_cyc();
        enable_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || multicycle_o !== 1'b1) begin
            failures++;
            $display("FAIL abort_calc: got ready=%b multicycle=%b expected 0/1", ready_o, multicycle_o);
        end
        next_cyc();
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || multicycle_o !== 1'b0 || result_o !== 32'h0) begin
            failures++;
            $display("FAIL abort_idle: got ready=%b multicycle=%b result=%h expected 1/0/00000000", ready_o, multicycle_o, result_o);
        end
        next_cyc();

        // Restart; change the inputs during CALC, which must have no effect.
        start_op(2'b00, 32'd9, 32'd2);
        next_cyc();
        op_a_i     = 32'hDEADBEEF;
        op_b_i     = 32'h0;
        operator_i = 2'b11;
        repeat (32) next_cyc();
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== 32'h00000004) begin
            failures++;
            $display("FAIL restart_9_2: got ready=%b result=%h expected ready=1 result=00000004", ready_o, result_o);
        end
        end_op();
    endtask

    task automatic test_back_to_back;
        start_op(2'b01, 32'hFFFFFF9C, 32'd7);
        repeat (33) next_cyc();
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== 32'hFFFFFFF2) begin
            failures++;
            $display("FAIL div_m100_7: got ready=%b result=%h expected ready=1 result=fffffff2", ready_o, result_o);
        end
        next_cyc();
        start_op(2'b00, 32'd50, 32'd5);
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || multicycle_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_start: got ready=%b multicycle=%b expected 0/0", ready_o, multicycle_o);
        end
        repeat (33) next_cyc();
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== 32'h0000000A) begin
            failures++;
            $display("FAIL b2b_50_5: got ready=%b result=%h expected ready=1 result=0000000a", ready_o, result_o);
        end
        end_op();
    endtask

    task automatic test_reset_mid;
        start_op(2'b00, 32'd1000, 32'd3);
        repeat (20) next_cyc();

        // Assert reset between clock edges: the outputs must clear at once.
        #2;
        rst_n    = 1'b0;
        enable_i = 1'b0;
        #1;
        checks++;
        if (multicycle_o !== 1'b0 || result_o !== 32'h0 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: got multicycle=%b result=%h ready=%b expected 0/00000000/1", multicycle_o, result_o, ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();

        start_op(2'b01, 32'd7, 32'hFFFFFFFE);
        repeat (33) next_cyc();
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL div_7_m2: got ready=%b result=%h expected ready=1 result=fffffffd", ready_o, result_o);
        end
        end_op();
    endtask

    initial begin
        rst_n      = 1'b0;
        enable_i   = 1'b0;
        operator_i = 2'b00;
        op_a_i     = 32'h0;
        op_b_i     = 32'h0;
        ex_ready_i = 1'b0;

        test_reset();
        test_divu_basic();
        test_signed();
        test_special();
        test_hold();
        test_abort();
        test_back_to_back();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
